// File: rtl/pipe_stall_ctrl_if.sv
// Stall/flush controller bundle: per-stage stall requests and flush/clear
// controls in, the stall vector, flush, watchdog and performance counters out.
interface pipe_stall_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 stallreq_if;
  logic                 stallreq_id;
  logic                 stallreq_ex;
  logic                 stallreq_mem;
  logic                 flush_req;
  logic                 cnt_clr;
  logic [5:0]           stall;
  logic                 flush;
  logic                 hang;
  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] stall_cycles;
  logic [CNT_WIDTH-1:0] stall_events;

  // Requesting side: pipeline stages and the performance monitor.
  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, flush_req, cnt_clr,
    input  stall, flush, hang, state, stall_cycles, stall_events
  );

  // Controller side.
  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, flush_req, cnt_clr,
    output stall, flush, hang, state, stall_cycles, stall_events
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 6-stage pipeline.
// The deepest stalling stage freezes itself and every stage upstream of it;
// flush squashes the pipeline and overrides any stall. A watchdog on the
// length of an unbroken stall run flags a hung pipeline until flushed.
module pipe_stall_ctrl #(
  parameter int WDOG_LIMIT = 256,
  parameter int CNT_WIDTH  = 32
) (
  input logic             clk,
  input logic             rst,
  pipe_stall_ctrl_if.slave bus
);

  localparam int RL_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [RL_W-1:0] RL_MAX  = RL_W'(WDOG_LIMIT);
  localparam logic [RL_W-1:0] RL_HANG = RL_W'(WDOG_LIMIT - 1);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    HANG  = 2'b10
  } state_t;

  state_t               state_q, state_d;
  logic [RL_W-1:0]      run_len_q, run_len_d;
  logic                 prev_stalled_q;
  logic [CNT_WIDTH-1:0] cycles_q, events_q;
  logic [5:0]           stall_vec;
  logic                 any_stall;

  function automatic logic [CNT_WIDTH-1:0] cnt_sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [RL_W-1:0] run_sat_inc(input logic [RL_W-1:0] v);
    return (v == RL_MAX) ? v : v + {{(RL_W-1){1'b0}}, 1'b1};
  endfunction

  // Merge stage requests: deepest requester wins; reset and flush force no stall.
  always_comb begin
    stall_vec = 6'b000000;
    if (!rst && !bus.flush_req) begin
      if (bus.stallreq_mem)      stall_vec = 6'b011111;
      else if (bus.stallreq_ex)  stall_vec = 6'b001111;
      else if (bus.stallreq_id)  stall_vec = 6'b000111;
      else if (bus.stallreq_if)  stall_vec = 6'b000011;
    end
  end

  assign any_stall = |stall_vec;

  // Next state and stall-run length; HANG is left only by flush (or reset).
  always_comb begin
    state_d   = state_q;
    run_len_d = any_stall ? run_sat_inc(run_len_q) : '0;
    case (state_q)
      RUN:     if (any_stall) state_d = STALL;
      STALL: begin
        if (!any_stall)                state_d = RUN;
        else if (run_len_q == RL_HANG) state_d = HANG;
      end
      HANG:    if (bus.flush_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      run_len_q      <= '0;
      prev_stalled_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      run_len_q      <= run_len_d;
      prev_stalled_q <= any_stall;
    end
  end

  // Saturating performance counters; a clear beats a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) begin
      cycles_q <= '0;
      events_q <= '0;
    end else begin
      if (any_stall)                   cycles_q <= cnt_sat_inc(cycles_q);
      if (any_stall && !prev_stalled_q) events_q <= cnt_sat_inc(events_q);
    end
  end

  assign bus.stall        = stall_vec;
  assign bus.flush        = bus.flush_req & ~rst;
  assign bus.hang         = (state_q == HANG);
  assign bus.state        = state_q;
  assign bus.stall_cycles = cycles_q;
  assign bus.stall_events = events_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl. The main instance uses a short
// watchdog (4) and wide counters; a second instance with 3-bit counters
// exercises counter saturation. Both receive identical stimulus.
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.CNT_WIDTH(32)) m ();
  pipe_stall_ctrl_if #(.CNT_WIDTH(3))  s ();

  pipe_stall_ctrl #(.WDOG_LIMIT(4), .CNT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (m.slave)
  );

  pipe_stall_ctrl #(.WDOG_LIMIT(16), .CNT_WIDTH(3)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (s.slave)
  );

  // req = {mem, ex, id, if}; registered expectations describe the values
  // visible during the cycle, i.e. the result of all earlier edges.
  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       fl;
    logic       clr;
    logic [5:0] stall;
    logic       flush;
    logic       chk;
    logic [1:0] st;
    logic       hang;
    int         cyc;
    int         evt;
  } vec_t;

  vec_t tv[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic r, input logic [3:0] q, input logic f, input logic c,
                     input logic [5:0] es, input logic ef, input logic ck,
                     input logic [1:0] est, input logic eh, input int ec, input int ee);
    vec_t v;
    v.rst = r; v.req = q; v.fl = f; v.clr = c; v.stall = es; v.flush = ef;
    v.chk = ck; v.st = est; v.hang = eh; v.cyc = ec; v.evt = ee;
    tv.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [3:0] q, input logic f, input logic c);
    rst            = r;
    m.stallreq_if  = q[0]; s.stallreq_if  = q[0];
    m.stallreq_id  = q[1]; s.stallreq_id  = q[1];
    m.stallreq_ex  = q[2]; s.stallreq_ex  = q[2];
    m.stallreq_mem = q[3]; s.stallreq_mem = q[3];
    m.flush_req    = f;    s.flush_req    = f;
    m.cnt_clr      = c;    s.cnt_clr      = c;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q, input logic f, input logic c);
    @(negedge clk);
    drive(r, q, f, c);
    #1;
  endtask

  initial begin
    drive(1'b1, 4'b0000, 1'b0, 1'b0);

    //  rst req     fl  clr  stall      fl  chk st     hg cyc evt
    add(1, 4'b1111, 1, 0, 6'b000000, 0, 0, 2'b00, 0, 0, 0);
    add(1, 4'b1111, 1, 0, 6'b000000, 0, 1, 2'b00, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 6'b000000, 0, 1, 2'b00, 0, 0, 0);
    add(0, 4'b0100, 0, 0, 6'b001111, 0, 1, 2'b00, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 6'b000000, 0, 1, 2'b01, 0, 1, 1);
    add(0, 4'b1010, 0, 0, 6'b011111, 0, 1, 2'b00, 0, 1, 1);
    add(0, 4'b0010, 0, 0, 6'b000111, 0, 1, 2'b01, 0, 2, 2);
    add(0, 4'b0000, 0, 0, 6'b000000, 0, 1, 2'b01, 0, 3, 2);
    add(0, 4'b0100, 1, 0, 6'b000000, 1, 1, 2'b00, 0, 3, 2);
    add(0, 4'b0000, 0, 0, 6'b000000, 0, 1, 2'b00, 0, 3, 2);
    add(0, 4'b0001, 0, 0, 6'b000011, 0, 1, 2'b00, 0, 3, 2);
    add(0, 4'b0101, 0, 0, 6'b001111, 0, 1, 2'b01, 0, 4, 3);
    add(0, 4'b0000, 0, 0, 6'b000000, 0, 1, 2'b01, 0, 5, 3);
    add(0, 4'b0000, 0, 0, 6'b000000, 0, 1, 2'b00, 0, 5, 3);
    add(0, 4'b0010, 0, 0, 6'b000111, 0, 1, 2'b00, 0, 5, 3);
    add(0, 4'b0010, 0, 0, 6'b000111, 0, 1, 2'b01, 0, 6, 4);
    add(0, 4'b0010, 0, 0, 6'b000111, 0, 1, 2'b01, 0, 7, 4);
    add(0, 4'b0010, 0, 0, 6'b000111, 0, 1, 2'b01, 0, 8, 4);
    add(0, 4'b0000, 0, 0, 6'b000000, 0, 1, 2'b10, 1, 9, 4);
    add(0, 4'b0100, 0, 0, 6'b001111, 0, 1, 2'b10, 1, 9, 4);
    add(0, 4'b0000, 0, 0, 6'b000000, 0, 1, 2'b10, 1, 10, 5);
    add(0, 4'b0000, 1, 0, 6'b000000, 1, 1, 2'b10, 1, 10, 5);
    add(0, 4'b0000, 0, 0, 6'b000000, 0, 1, 2'b00, 0, 10, 5);
    add(0, 4'b1000, 0, 1, 6'b011111, 0, 1, 2'b00, 0, 10, 5);
    add(0, 4'b1000, 0, 0, 6'b011111, 0, 1, 2'b01, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 6'b000000, 0, 1, 2'b01, 0, 1, 0);
    add(0, 4'b0000, 0, 1, 6'b000000, 0, 1, 2'b00, 0, 1, 0);
    add(0, 4'b0000, 0, 0, 6'b000000, 0, 1, 2'b00, 0, 0, 0);
    add(0, 4'b0100, 0, 0, 6'b001111, 0, 1, 2'b00, 0, 0, 0);
    add(0, 4'b0100, 0, 0, 6'b001111, 0, 1, 2'b01, 0, 1, 1);
    add(1, 4'b0100, 0, 0, 6'b000000, 0, 1, 2'b01, 0, 2, 1);
    add(0, 4'b0000, 0, 0, 6'b000000, 0, 1, 2'b00, 0, 0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].rst, tv[i].req, tv[i].fl, tv[i].clr);
      check($sformatf("v%0d.stall", i), 32'(m.stall), 32'(tv[i].stall));
      check($sformatf("v%0d.flush", i), 32'(m.flush), 32'(tv[i].flush));
      if (tv[i].chk) begin
        check($sformatf("v%0d.state", i), 32'(m.state), 32'(tv[i].st));
        check($sformatf("v%0d.hang", i), 32'(m.hang), 32'(tv[i].hang));
        check($sformatf("v%0d.cycles", i), m.stall_cycles, 32'(tv[i].cyc));
        check($sformatf("v%0d.events", i), m.stall_events, 32'(tv[i].evt));
      end
    end

    // Reset taken while hung returns everything to reset values.
    step(0, 4'b0000, 0, 1);
    for (int k = 0; k < 4; k++) step(0, 4'b1000, 0, 0);
    step(0, 4'b0000, 0, 0);
    check("hang_before_rst", 32'(m.hang), 32'd1);
    check("state_before_rst", 32'(m.state), 32'd2);
    step(1, 4'b1000, 0, 0);
    step(0, 4'b0000, 0, 0);
    check("hang_after_rst", 32'(m.hang), 32'd0);
    check("state_after_rst", 32'(m.state), 32'd0);
    check("cycles_after_rst", m.stall_cycles, 32'd0);
    check("events_after_rst", m.stall_events, 32'd0);

    // Saturation on 3-bit counters: nine separate one-cycle episodes.
    for (int k = 1; k <= 9; k++) begin
      step(0, 4'b0100, 0, 0);
      step(0, 4'b0000, 0, 0);
      check($sformatf("sat%0d.cycles", k), 32'(s.stall_cycles), 32'((k > 7) ? 7 : k));
      check($sformatf("sat%0d.events", k), 32'(s.stall_events), 32'((k > 7) ? 7 : k));
    end
    check("sat.state", 32'(s.state), 32'd1);

    // Clear during a stalled cycle with counters at 7.
    step(0, 4'b1000, 0, 1);
    check("clr.stall", 32'(s.stall), 32'b011111);
    step(0, 4'b0000, 0, 0);
    check("clr.cycles", 32'(s.stall_cycles), 32'd0);
    check("clr.events", 32'(s.stall_events), 32'd0);
    check("clr.state", 32'(s.state), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
